enc16_4_pend: RTL and testbench
===============================

Name: enc16_4_pend

Overview:
- Registered 16-to-4 priority encoder with a request-pending latch and a valid/ack output handshake.
- It is the inverse path of the team's 4-to-16 decoder. One-hot or multi-hot request lines D are captured into a pending register. The highest-index pending request is presented as a 4-bit index I.
- The index is held stable until the consumer acknowledges it, and the acknowledged bit is then cleared.
- Sits between request sources (e.g. decoder-driven strobes, interrupt-style lines) and a single consumer of encoded indices.

Parameters:
- N, 16, number of request lines.
- W, 4, index width; must satisfy 2**W == N.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  capture enable; when 0, D is ignored and the pending state is kept.
- D  input  N  request lines; bit k requests index k. Level is sampled every cycle.
- ack  input  1  consumer accepts the current I; only meaningful while valid=1.
- I  output  W  encoded index of the presented request.
- valid  output  1  I holds a presented, unacknowledged request.
- pend  output  N  pending-request register, visible for debug and verification.
- ovf  output  1  sticky flag: a request hit a bit that was already pending.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - pend=0, I=0, valid=0, ovf=0, FSM=IDLE.
  - Reset asserted mid-presentation drops all pending and presented requests.
- Request capture, every cycle: set = en ? D : 0.
- Clear mask:
  - clr = one-hot(I) when state=PRESENT and ack=1; otherwise clr = 0.
- Pending update: pend_next = (pend & ~clr) | set.
  - Set wins over clear on the same bit in the same cycle. The bit stays pending and is treated as a fresh request, so ovf is not set.
- Overflow: ovf is set to 1 when (set & pend & ~clr) != 0. It stays at 1 until reset.
- FSM, IDLE:
  - valid=0.
  - If pend != 0, the next edge loads I = highest set index of pend (index 15 has top priority), sets valid=1, and moves to PRESENT.
  - Selection uses the registered pend, not pend_next.
- FSM, PRESENT:
  - valid=1 and I is held stable regardless of new requests or en.
  - When ack=1, the next edge clears pend[I], sets valid=0, and moves to IDLE.
  - When ack=0, the FSM stays in PRESENT.
- Latency:
  - D sampled at edge t appears in pend after edge t. valid/I appear after edge t+1, provided the FSM is in IDLE.
  - Each ack is followed by one IDLE bubble cycle before the next request is presented, so maximum throughput is 1 index per 2 cycles.
- Higher-priority arrival while in PRESENT does not preempt the presented I. It is presented next.
- ack while valid=0 is ignored and has no effect on pend.
- I keeps its last value while valid=0. Consumers must qualify I with valid.
- en=0 freezes capture only; presentation and ack handling continue normally.

Test Plan:
- Reset check: hold rst_n=0 with D=16'hFFFF, en=1 -> pend=0, valid=0, I=0, ovf=0. Release rst_n -> after 2 edges valid=1, I=15.
- Single request sweep: for k=0..15, pulse D=1<<k for 1 cycle with en=1, then ack on the first valid -> I=k, valid=1 exactly 2 edges after the pulse, pend=0 after the ack edge, ovf=0.
- Priority ordering: one-cycle pulse D=16'h8421, then ack each presentation -> indices in order 15, 10, 5, 0, each separated by one valid=0 cycle; pend ends at 0.
- Hold and no preemption: present I=3 and hold ack=0 for 5 cycles while pulsing D bit 12 -> I stays 3 and valid stays 1. After ack, I=12 on the following presentation.
- Enable gating and ack-when-idle: en=0 with D=16'h00FF for 4 cycles -> pend=0, valid=0; ack pulses in that window have no effect. Then en=1 for 1 cycle -> I=7 presented.
- Overflow and set-over-clear:
  - Pulse bit 2 twice while it is pending (not in the ack cycle) -> ovf=1, sticky until rst_n.
  - Separately, assert bit 2 in the same cycle as its ack -> pend[2] remains 1, ovf unchanged, and I=2 is presented again after the bubble.

Source files
------------

// File: rtl/enc16_4_pend.sv
// Registered 16-to-4 priority encoder with a pending-request latch and a
// valid/ack handshake on the presented index.
module enc16_4_pend #(
  parameter int unsigned N = 16,
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] D,
  input  logic         ack,
  output logic [W-1:0] I,
  output logic         valid,
  output logic [N-1:0] pend,
  output logic         ovf
);

  typedef enum logic {
    ST_IDLE,
    ST_PRESENT
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic [W-1:0] i_q, i_d;
  logic         valid_q, valid_d;
  logic         ovf_q, ovf_d;

  logic [N-1:0] set_c;
  logic [N-1:0] clr_c;
  logic [W-1:0] top_idx_c;

  // Highest-index pending bit; later iterations override earlier ones.
  always_comb begin
    top_idx_c = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (pend_q[k]) top_idx_c = W'(k);
    end
  end

  // Pending update, sticky overflow and presentation FSM.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    valid_d = valid_q;
    set_c   = en ? D : '0;
    clr_c   = '0;

    if (state_q == ST_PRESENT && ack) clr_c = N'(1) << i_q;

    // A set on the bit being cleared counts as a fresh request, not overflow.
    pend_d = (pend_q & ~clr_c) | set_c;
    ovf_d  = ovf_q | (|(set_c & pend_q & ~clr_c));

    unique case (state_q)
      ST_IDLE: begin
        if (|pend_q) begin
          i_d     = top_idx_c;
          valid_d = 1'b1;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (ack) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      i_q     <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      i_q     <= i_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign I     = i_q;
  assign valid = valid_q;
  assign pend  = pend_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_enc16_4_pend.sv
// Bench for enc16_4_pend: behavioural model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_enc16_4_pend;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] D;
  logic        ack;
  logic [3:0]  I;
  logic        valid;
  logic [15:0] pend;
  logic        ovf;

  int n_vec;
  int n_err;

  enc16_4_pend dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .D     (D),
    .ack   (ack),
    .I     (I),
    .valid (valid),
    .pend  (pend),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: outstanding requests, the presented index and whether one is shown.
  logic [15:0] m_pend;
  logic [3:0]  m_i;
  logic        m_valid;
  logic        m_ovf;

  function automatic logic [3:0] highest(input logic [15:0] v);
    for (int k = 15; k >= 0; k--) begin
      if (v[k]) return 4'(k);
    end
    return 4'd0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [15:0] s;
    logic [15:0] c;
    if (!rst_n) begin
      m_pend  = 16'h0;
      m_i     = 4'd0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      s = en ? D : 16'h0;
      c = 16'h0;
      if (m_valid && ack) c[m_i] = 1'b1;
      if ((s & m_pend & ~c) != 16'h0) m_ovf = 1'b1;
      if (!m_valid) begin
        if (m_pend != 16'h0) begin
          m_i     = highest(m_pend);
          m_valid = 1'b1;
        end
      end else if (ack) begin
        m_valid = 1'b0;
      end
      m_pend = (m_pend & ~c) | s;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("model_I",     32'(I),     32'(m_i));
    check("model_valid", 32'(valid), 32'(m_valid));
    check("model_pend",  32'(pend),  32'(m_pend));
    check("model_ovf",   32'(ovf),   32'(m_ovf));
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid(input int max_cyc, output int waited);
    waited = 0;
    while (valid !== 1'b1 && waited < max_cyc) begin
      tick();
      waited++;
    end
    check("wait_valid_timeout", 32'(valid), 32'd1);
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    D     = 16'h0;
    ack   = 1'b0;
    en    = 1'b1;
    tick();
    check("rst_pend", 32'(pend), 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    int w;
    int exp_idx[4];
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    en    = 1'b1;
    D     = 16'hFFFF;
    ack   = 1'b0;

    // Reset held with all requests asserted.
    tick();
    tick();
    check("rst_pend0",  32'(pend),  32'h0);
    check("rst_valid0", 32'(valid), 32'h0);
    check("rst_I0",     32'(I),     32'h0);
    check("rst_ovf0",   32'(ovf),   32'h0);
    rst_n = 1'b1;
    tick();
    check("rel_pend",   32'(pend),  32'hFFFF);
    check("rel_valid1", 32'(valid), 32'h0);
    tick();
    check("rel_valid2", 32'(valid), 32'h1);
    check("rel_I",      32'(I),     32'd15);
    do_reset();

    // Single request sweep.
    for (int k = 0; k < 16; k++) begin
      tick();
      D = 16'h1 << k;
      tick();
      D = 16'h0;
      check("sweep_valid_lat1", 32'(valid), 32'h0);
      tick();
      check("sweep_valid", 32'(valid), 32'h1);
      check("sweep_I",     32'(I),     32'(k));
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("sweep_pend", 32'(pend), 32'h0);
      check("sweep_ovf",  32'(ovf),  32'h0);
    end

    // Priority ordering from a multi-hot pulse.
    tick();
    D = 16'h8421;
    tick();
    D = 16'h0;
    exp_idx = '{15, 10, 5, 0};
    for (int j = 0; j < 4; j++) begin
      wait_valid(4, w);
      check("prio_gap", 32'(w), 32'd1);
      check("prio_I",   32'(I), 32'(exp_idx[j]));
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("prio_bubble", 32'(valid), 32'h0);
    end
    check("prio_pend_end", 32'(pend), 32'h0);

    // Hold without preemption.
    D = 16'h1 << 3;
    tick();
    D = 16'h0;
    tick();
    check("hold_I3", 32'(I), 32'd3);
    D = 16'h1 << 12;
    for (int j = 0; j < 5; j++) begin
      tick();
      D = 16'h0;
      check("hold_I",     32'(I),     32'd3);
      check("hold_valid", 32'(valid), 32'h1);
    end
    check("hold_pend", 32'(pend), 32'h1008);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    wait_valid(4, w);
    check("hold_next_I", 32'(I), 32'd12);
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // Enable gating with stray acks while idle.
    en = 1'b0;
    D  = 16'h00FF;
    for (int j = 0; j < 4; j++) begin
      ack = (j % 2 == 0);
      tick();
      check("gate_pend",  32'(pend),  32'h0);
      check("gate_valid", 32'(valid), 32'h0);
    end
    ack = 1'b0;
    en  = 1'b1;
    tick();
    D = 16'h0;
    check("gate_pend_cap", 32'(pend), 32'h00FF);
    wait_valid(4, w);
    check("gate_I", 32'(I), 32'd7);
    do_reset();

    // Overflow: re-request a pending bit outside its ack cycle.
    tick();
    D = 16'h0004;
    tick();
    check("ovf_pre", 32'(ovf), 32'h0);
    tick();
    D = 16'h0;
    check("ovf_set",   32'(ovf),   32'h1);
    check("ovf_I",     32'(I),     32'd2);
    check("ovf_valid", 32'(valid), 32'h1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    tick();
    check("ovf_sticky", 32'(ovf),  32'h1);
    check("ovf_pend",   32'(pend), 32'h0);
    do_reset();
    tick();
    check("ovf_cleared", 32'(ovf), 32'h0);

    // Set wins over clear on the acknowledged bit.
    D = 16'h0004;
    tick();
    D = 16'h0;
    wait_valid(4, w);
    check("soc_I", 32'(I), 32'd2);
    ack = 1'b1;
    D   = 16'h0004;
    tick();
    ack = 1'b0;
    D   = 16'h0;
    check("soc_pend",  32'(pend),  32'h0004);
    check("soc_valid", 32'(valid), 32'h0);
    check("soc_ovf",   32'(ovf),   32'h0);
    tick();
    check("soc_valid2", 32'(valid), 32'h1);
    check("soc_I2",     32'(I),     32'd2);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("soc_pend_end", 32'(pend), 32'h0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
    $fatal(1);
  end

endmodule
